// File: rtl/data_mem_responder.sv
// Halfword data memory responder with a registered read port and low/high pair reassembly into a 32-bit word.
// Optional access-error reporting is enabled by defining DMEM_ERR_EN.
module data_mem_responder #(
  parameter int unsigned DEPTH_HW  = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] mem_addr_i,
  input  logic [15:0] mem_data_i,
  input  logic        mem_re_i,
  input  logic        mem_we_i,
  output logic [15:0] mem_data_o,
  output logic [31:0] word_o,
  output logic        word_valid_o,
  output logic        err_o
);

  localparam int unsigned AW = $clog2(DEPTH_HW);

  typedef enum logic {ST_LO, ST_HI} state_t;

  state_t      state_q, state_d;
  logic [15:0] mem [DEPTH_HW];
  logic [31:0] off;
  logic [AW-1:0] idx;
  logic [15:0] rd_data;
  logic        oob;
  logic        wr_en, rd_en, rd_sup;
  logic [15:0] lo_q, lo_d;
  logic [31:0] lo_addr_q, lo_addr_d;
  logic [31:0] word_q, word_d;
  logic        valid_q, valid_d;
  logic [15:0] data_q, data_d;
  logic        err_q, err_d;

  assign off     = mem_addr_i - BASE_ADDR;
  assign idx     = off[AW:1];
  assign rd_data = mem[idx];

`ifdef DMEM_ERR_EN
  // Indices past the array are rejected instead of aliasing onto low entries.
  assign oob = |off[31:AW+1];
  logic unused_off;
  assign unused_off = off[0];
`else
  assign oob = 1'b0;
  logic unused_off;
  assign unused_off = ^{off[31:AW+1], off[0]};
`endif

  assign wr_en  = mem_we_i & ~oob;
  assign rd_en  = mem_re_i & ~mem_we_i & ~oob;
  assign rd_sup = mem_re_i & ~mem_we_i & oob;

  always_ff @(posedge clk_i) begin
    if (wr_en) mem[idx] <= mem_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_LO;
      lo_q      <= '0;
      lo_addr_q <= '0;
      word_q    <= '0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      lo_q      <= lo_d;
      lo_addr_q <= lo_addr_d;
      word_q    <= word_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    lo_d      = lo_q;
    lo_addr_d = lo_addr_q;
    word_d    = word_q;
    valid_d   = 1'b0;
    data_d    = data_q;
    err_d     = 1'b0;

    if (mem_we_i) begin
      // Any write breaks the read pair, even one that also carried a read.
      state_d = ST_LO;
    end else if (rd_en) begin
      data_d = rd_data;
      case (state_q)
        ST_LO: begin
          lo_d      = rd_data;
          lo_addr_d = mem_addr_i;
          state_d   = ST_HI;
        end
        ST_HI: begin
          if (mem_addr_i == lo_addr_q + 32'd2) begin
            word_d  = {rd_data, lo_q};
            valid_d = 1'b1;
            state_d = ST_LO;
          end else begin
            lo_d      = rd_data;
            lo_addr_d = mem_addr_i;
`ifdef DMEM_ERR_EN
            err_d     = 1'b1;
`endif
          end
        end
        default: state_d = ST_LO;
      endcase
    end else if (rd_sup) begin
      data_d = '0;
    end

`ifdef DMEM_ERR_EN
    if ((mem_re_i || mem_we_i) && (oob || mem_addr_i[0])) err_d = 1'b1;
    if (mem_re_i && mem_we_i) err_d = 1'b1;
`endif
  end

  assign mem_data_o   = data_q;
  assign word_o       = word_q;
  assign word_valid_o = valid_q;
  assign err_o        = err_q;

endmodule
